control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//   Timing-and-control unit of the SAP CPU. It drives the load/enable strobes
//   (pc_out, pc_inc, jump, mar_in, ir_in, ...) that every bus-attached register
//   obeys, sequencing fetch (T1-T3) and execute (T4-T6) per instruction.
//   It sits beside the instruction register and reads its opcode nibble.
// PARAMETERS
//   EARLY_END   1   1: return to T1 right after the last active execute state;
//                   0: always run T4..T6.
// PORTS
//   clock    in   1  single system clock; all state changes on posedge
//   reset    in   1  synchronous, active-high; forces IDLE
//   run      in   1  advance enable; state holds while 0
//   opcode   in   4  IR[7:4], valid from T4 onward
//   pc_out   out  1  PC drives bus
//   pc_inc   out  1  PC increments
//   jump     out  1  PC loads from bus
//   mar_in   out  1  MAR loads from bus
//   ram_out  out  1  RAM drives bus
//   ir_in    out  1  IR loads from bus
//   ir_out   out  1  IR operand nibble drives bus
//   a_in     out  1  accumulator loads
//   a_out    out  1  accumulator drives bus
//   b_in     out  1  B register loads
//   alu_out  out  1  ALU drives bus
//   sub      out  1  ALU subtract select
//   out_in   out  1  output register loads
//   halt     out  1  CPU halted
//   tstate   out  3  0=IDLE, 1..6=T1..T6, 7=HALT (debug)
// BEHAVIOUR
//   - State register only; all strobes are combinational decode of
//     {state, opcode}. At most one bus driver is asserted in any state.
//   - Reset (any cycle, incl. mid-instruction or HALT): state<=IDLE on the next
//     edge; in IDLE every strobe=0, halt=0, tstate=0.
//   - State advances one step per clock only when run=1; run=0 freezes state.
//     Strobes stay asserted while frozen.
//   - IDLE -> T1 when run=1.
//   - Fetch, all opcodes:
//       T1: pc_out, mar_in
//       T2: pc_inc
//       T3: ram_out, ir_in
//   - Execute:
//       LDA 0000: T4 ir_out,mar_in; T5 ram_out,a_in
//       ADD 0001: T4 ir_out,mar_in; T5 ram_out,b_in; T6 alu_out,a_in
//       SUB 0010: as ADD, with sub=1 in T5 and T6
//       JMP 0011: T4 ir_out,jump
//       OUT 1110: T4 a_out,out_in
//       HLT 1111: T4 -> HALT
//       Any other opcode: NOP, no strobes T4..T6
//   - EARLY_END=1: LDA T5->T1; JMP/OUT/NOP T4->T1; ADD/SUB T6->T1.
//     EARLY_END=0: all instructions pass T6->T1.
//   - HALT: absorbing state. halt=1, all other strobes 0, ignores run; only
//     reset exits.
//   - tstate is a 3-bit encoding; value 7 is reached only via HLT.
// TESTING
//   1. reset=1 for 2 cycles, then run=1 -> IDLE with all strobes 0; next edge
//      T1 with pc_out=mar_in=1.
//   2. opcode=0001, EARLY_END=1 -> T1..T6 sequence exact; T6 alu_out=a_in=1,
//      sub=0; then T1 again.
//   3. opcode=0010 -> sub=1 only in T5/T6. opcode=0011 -> T4 jump=ir_out=1;
//      next state T1.
//   4. opcode=1111 -> HALT after T4, halt=1, tstate=7; toggling run 20 cycles
//      changes nothing; reset -> IDLE.
//   5. run=0 for 3 cycles in T5 of LDA -> state and ram_out/a_in held; resumes
//      to T1.
//   6. reset asserted in T3 and in T6 (EARLY_END=0, opcode=0101) -> IDLE next
//      edge; all strobes 0; no two bus drivers ever high (assertion check).

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: timing-and-control unit of the SAP CPU.
// A single state register steps through fetch (T1-T3) and execute (T4-T6);
// every bus strobe is a combinational decode of the current state and opcode.
module control_sequencer #(
    parameter bit EARLY_END = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       jump,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       sub,
    output logic       out_in,
    output logic       halt,
    output logic [2:0] tstate
);

    // State encoding doubles as the tstate debug value.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_T3   = 3'd3;
    localparam logic [2:0] S_T4   = 3'd4;
    localparam logic [2:0] S_T5   = 3'd5;
    localparam logic [2:0] S_T6   = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       one_step_exec;

    // Instructions whose execute phase is finished after T4 (JMP, OUT, NOPs).
    assign one_step_exec = (opcode != OP_LDA) && (opcode != OP_ADD) &&
                           (opcode != OP_SUB) && (opcode != OP_HLT);

    // State register: reset wins over everything, including HALT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; run=0 freezes every state, HALT is absorbing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_T1;
            S_T1:   if (run) state_d = S_T2;
            S_T2:   if (run) state_d = S_T3;
            S_T3:   if (run) state_d = S_T4;
            S_T4: begin
                if (run) begin
                    if (opcode == OP_HLT) begin
                        state_d = S_HALT;
                    end else if (EARLY_END && one_step_exec) begin
                        state_d = S_T1;
                    end else begin
                        state_d = S_T5;
                    end
                end
            end
            S_T5: begin
                if (run) begin
                    if (EARLY_END && (opcode == OP_LDA)) begin
                        state_d = S_T1;
                    end else begin
                        state_d = S_T6;
                    end
                end
            end
            S_T6:   if (run) state_d = S_T1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe decode from {state, opcode}; only one bus driver per state.
    always_comb begin
        pc_out  = 1'b0;
        pc_inc  = 1'b0;
        jump    = 1'b0;
        mar_in  = 1'b0;
        ram_out = 1'b0;
        ir_in   = 1'b0;
        ir_out  = 1'b0;
        a_in    = 1'b0;
        a_out   = 1'b0;
        b_in    = 1'b0;
        alu_out = 1'b0;
        sub     = 1'b0;
        out_in  = 1'b0;
        halt    = 1'b0;
        case (state_q)
            S_T1: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
            end
            S_T2: pc_inc = 1'b1;
            S_T3: begin
                ram_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        ir_out = 1'b1;
                        mar_in = 1'b1;
                    end
                    OP_JMP: begin
                        ir_out = 1'b1;
                        jump   = 1'b1;
                    end
                    OP_OUT: begin
                        a_out  = 1'b1;
                        out_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (opcode)
                    OP_LDA: begin
                        ram_out = 1'b1;
                        a_in    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ram_out = 1'b1;
                        b_in    = 1'b1;
                        sub     = (opcode == OP_SUB);
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    alu_out = 1'b1;
                    a_in    = 1'b1;
                    sub     = (opcode == OP_SUB);
                end
            end
            S_HALT: halt = 1'b1;
            default: ;
        endcase
    end

    assign tstate = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: one instance with EARLY_END=1 and
// one with EARLY_END=0 share clock/reset/run; each has its own opcode stream.
module tb_control_sequencer;

    // Strobe bit positions in the packed expectation vector.
    localparam logic [13:0] M_PC_OUT  = 14'h2000;
    localparam logic [13:0] M_PC_INC  = 14'h1000;
    localparam logic [13:0] M_JUMP    = 14'h0800;
    localparam logic [13:0] M_MAR_IN  = 14'h0400;
    localparam logic [13:0] M_RAM_OUT = 14'h0200;
    localparam logic [13:0] M_IR_IN   = 14'h0100;
    localparam logic [13:0] M_IR_OUT  = 14'h0080;
    localparam logic [13:0] M_A_IN    = 14'h0040;
    localparam logic [13:0] M_A_OUT   = 14'h0020;
    localparam logic [13:0] M_B_IN    = 14'h0010;
    localparam logic [13:0] M_ALU_OUT = 14'h0008;
    localparam logic [13:0] M_SUB     = 14'h0004;
    localparam logic [13:0] M_OUT_IN  = 14'h0002;
    localparam logic [13:0] M_HALT    = 14'h0001;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       run   = 1'b0;
    logic [3:0] opc0  = 4'd0;
    logic [3:0] opc1  = 4'd0;
    wire [13:0] str0;
    wire [13:0] str1;
    wire [2:0]  ts0;
    wire [2:0]  ts1;

    always #5 clock = ~clock;

    control_sequencer #(.EARLY_END(1'b1)) dut0 (
        .clock(clock), .reset(reset), .run(run), .opcode(opc0),
        .pc_out(str0[13]), .pc_inc(str0[12]), .jump(str0[11]), .mar_in(str0[10]),
        .ram_out(str0[9]), .ir_in(str0[8]), .ir_out(str0[7]), .a_in(str0[6]),
        .a_out(str0[5]), .b_in(str0[4]), .alu_out(str0[3]), .sub(str0[2]),
        .out_in(str0[1]), .halt(str0[0]), .tstate(ts0)
    );

    control_sequencer #(.EARLY_END(1'b0)) dut1 (
        .clock(clock), .reset(reset), .run(run), .opcode(opc1),
        .pc_out(str1[13]), .pc_inc(str1[12]), .jump(str1[11]), .mar_in(str1[10]),
        .ram_out(str1[9]), .ir_in(str1[8]), .ir_out(str1[7]), .a_in(str1[6]),
        .a_out(str1[5]), .b_in(str1[4]), .alu_out(str1[3]), .sub(str1[2]),
        .out_in(str1[1]), .halt(str1[0]), .tstate(ts1)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: mode 0=idle, 1=running instruction, 2=halted.
    int         m_mode[2];
    int         m_step[2];
    logic [3:0] m_op[2];
    int         force_op[2];
    logic [16:0] q0[$];
    logic [16:0] q1[$];

    // Micro-operations of step s (0-based: 0..2 fetch, 3..5 execute).
    function automatic logic [13:0] micro(input logic [3:0] op, input int s);
        logic [13:0] m;
        m = '0;
        case (s)
            0: m = M_PC_OUT | M_MAR_IN;
            1: m = M_PC_INC;
            2: m = M_RAM_OUT | M_IR_IN;
            default: begin
                case (op)
                    4'd0: if (s == 3) m = M_IR_OUT | M_MAR_IN;
                          else if (s == 4) m = M_RAM_OUT | M_A_IN;
                    4'd1, 4'd2: begin
                        if (s == 3) m = M_IR_OUT | M_MAR_IN;
                        else if (s == 4) m = M_RAM_OUT | M_B_IN | ((op == 4'd2) ? M_SUB : 14'h0);
                        else m = M_ALU_OUT | M_A_IN | ((op == 4'd2) ? M_SUB : 14'h0);
                    end
                    4'd3:  if (s == 3) m = M_IR_OUT | M_JUMP;
                    4'd14: if (s == 3) m = M_A_OUT | M_OUT_IN;
                    default: m = '0;
                endcase
            end
        endcase
        return m;
    endfunction

    // Number of T-states an instruction occupies before returning to T1.
    function automatic int instr_len(input logic [3:0] op, input bit ee);
        if (!ee) return 6;
        if (op == 4'd0) return 5;
        if (op == 4'd1 || op == 4'd2) return 6;
        return 4;
    endfunction

    function automatic logic [16:0] expect_of(input int k);
        if (m_mode[k] == 0) return 17'd0;
        if (m_mode[k] == 2) return {3'd7, M_HALT};
        return {3'(m_step[k] + 1), micro(m_op[k], m_step[k])};
    endfunction

    task automatic new_op(input int k);
        logic [3:0] o;
        if (force_op[k] >= 0) begin
            o = 4'(force_op[k]);
            force_op[k] = -1;
        end else begin
            o = 4'($urandom_range(0, 15));
        end
        m_op[k] = o;
        if (k == 0) opc0 = o;
        else        opc1 = o;
    endtask

    task automatic model_step(input int k, input bit r, input bit rn, input bit ee);
        if (r) begin
            m_mode[k] = 0;
        end else if (m_mode[k] == 2 || !rn) begin
            // frozen or halted
        end else if (m_mode[k] == 0) begin
            m_mode[k] = 1;
            m_step[k] = 0;
            new_op(k);
        end else if (m_step[k] == 3 && m_op[k] == 4'd15) begin
            m_mode[k] = 2;
        end else begin
            m_step[k] = m_step[k] + 1;
            if (m_step[k] == instr_len(m_op[k], ee)) begin
                m_step[k] = 0;
                new_op(k);
            end
        end
    endtask

    // One clock: apply reset/run, let the edge happen, advance model, queue expectations.
    task automatic cyc(input bit r, input bit rn);
        reset = r;
        run   = rn;
        @(posedge clock);
        #1;
        cycle++;
        model_step(0, r, rn, 1'b1);
        model_step(1, r, rn, 1'b0);
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
    endtask

    task automatic run_until(input int k, input int step, input logic [3:0] op, input string what);
        int n;
        n = 0;
        while (!(m_mode[k] == 1 && m_step[k] == step && m_op[k] == op) && n < 40) begin
            cyc(1'b0, 1'b1);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out after %0d cycles waiting for step %0d", what, n, step);
        end
    endtask

    task automatic compare(input int k, input logic [16:0] exp_v, input logic [2:0] ts, input logic [13:0] st);
        checks++;
        if ({ts, st} !== exp_v) begin
            errors++;
            $display("FAIL dut%0d cycle %0d got tstate=%0d strobes=%b expected tstate=%0d strobes=%b",
                     k, cycle, ts, st, exp_v[16:14], exp_v[13:0]);
        end
    endtask

    // Monitor: sample at the falling edge, pop one expectation per DUT per cycle.
    always @(negedge clock) begin
        logic [16:0] e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            compare(0, e, ts0, str0);
            checks++;
            if ($countones({str0[13], str0[9], str0[7], str0[5], str0[3]}) > 1) begin
                errors++;
                $display("FAIL bus_drivers dut0 cycle %0d got strobes=%b required at most one driver", cycle, str0);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            compare(1, e, ts1, str1);
            checks++;
            if ($countones({str1[13], str1[9], str1[7], str1[5], str1[3]}) > 1) begin
                errors++;
                $display("FAIL bus_drivers dut1 cycle %0d got strobes=%b required at most one driver", cycle, str1);
            end
        end
    end

    initial begin
        m_mode   = '{0, 0};
        m_step   = '{0, 0};
        m_op     = '{4'd0, 4'd0};
        force_op = '{-1, -1};

        // Reset for two cycles with run high, then first fetch.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        force_op[0] = 1;
        force_op[1] = 1;
        cyc(1'b0, 1'b1);
        repeat (8) cyc(1'b0, 1'b1);

        // SUB, then JMP on the early-ending instance.
        force_op[0] = 2;
        run_until(0, 0, 4'd2, "sub_start");
        force_op[0] = 3;
        run_until(0, 0, 4'd3, "jmp_start");
        repeat (5) cyc(1'b0, 1'b1);

        // LDA frozen in T5 for three cycles, then resumed.
        force_op[0] = 0;
        run_until(0, 4, 4'd0, "lda_t5");
        repeat (3) cyc(1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1);

        // HLT: absorbing regardless of run, exited only by reset.
        force_op[0] = 15;
        run_until(0, 3, 4'd15, "hlt_t4");
        cyc(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'(i % 2));
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);

        // NOP 0101 on the full-length instance, reset in T3 and in T6.
        force_op[1] = 5;
        cyc(1'b0, 1'b1);
        run_until(1, 2, 4'd5, "nop_t3");
        cyc(1'b1, 1'b1);
        force_op[1] = 5;
        cyc(1'b0, 1'b1);
        run_until(1, 5, 4'd5, "nop_t6");
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);

        // Randomized traffic: occasional stalls and rare resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0));
        end

        @(negedge clock);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain got q0=%0d q1=%0d pending required 0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
